q_proj_reader: RTL and testbench
================================

# q_proj_reader

Readout sequencer for the Q_PROJECTION result buffer. The write-window counter holds the buffer open for `DEPTH` cycles while results are written. This block is the other end of that buffer. On a `start` pulse it walks buffer addresses 0..DEPTH-1 and fetches each word from a registered-read memory. It presents each word on a valid/ready stream to the downstream consumer, then pulses `done`.

## Interface
- `DEPTH`, default 7: number of words read per transaction; must be ≥ 1.
- `DATA_W`, default 8: buffer/stream word width.
- `ADDR_W`, default `$clog2(DEPTH)` with a minimum of 1: width of `rd_addr`.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a transaction; sampled only in IDLE.
- `rd_en` out 1: buffer read strobe.
- `rd_addr` out ADDR_W: buffer read address.
- `rd_data` in DATA_W: buffer read data, valid in the cycle after `rd_en` was high.
- `out_data` out DATA_W: stream word.
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: consumer accepts the word.
- `out_par` out 1: even parity of `out_data` (see Configuration).
- `busy` out 1: transaction in progress, including the DONE cycle.
- `done` out 1: one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - All strobes low.
  - `start`=1 → READ with address counter = 0.
- READ:
  - `rd_en`=1, `rd_addr`=counter.
  - Next state is WAIT unconditionally.
- WAIT:
  - `rd_en`=0; `rd_data` is valid this cycle.
  - Next edge: `out_data`←`rd_data`, `out_valid`←1, → SEND.
- SEND:
  - `out_valid`=1; `out_data` stays stable until the handshake.
  - Handshake = `out_valid`&&`out_ready` at a rising edge.
  - On handshake with counter < DEPTH-1: counter+1, `out_valid`←0, → READ.
  - On handshake with counter == DEPTH-1: `out_valid`←0, → DONE.
  - No handshake: stay in SEND indefinitely (backpressure), with no re-read.
- DONE:
  - `done`=1 and `busy`=1 for exactly one cycle, then → IDLE.
- `busy`=1 in every state except IDLE.
- `start` is ignored in every state except IDLE, including DONE; it is never queued.
- Counter never exceeds DEPTH-1 and never wraps.
- With DEPTH=1: one word is read, then DONE.
- `out_data` keeps its last word after the transaction; only `out_valid` qualifies it.
- `out_ready` is don't-care while `out_valid`=0.
- `rst` asserted in any state → IDLE immediately, with every output at its reset value. An in-flight word is discarded and `done` is not issued.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `out_data`=0, `out_valid`=0, `out_par`=0, `busy`=0, `done`=0.
- Cycle numbering: `start` is high in cycle 0.
  - Cycle 1: READ (`rd_en`=1, `rd_addr`=0).
  - Cycle 2: WAIT.
  - Cycle 3: first `out_valid`=1.
- Latency from start to first valid is 3 cycles.
- With `out_ready` held high, one word is transferred per 3 cycles.
- Last handshake at the edge into cycle e:
  - `done`=1 in cycle e.
  - IDLE in cycle e+1; a new `start` is accepted in cycle e+1.
- All outputs are registered; no combinational path from `out_ready` or `start` to any output.

## Configuration
- `Q_READ_PARITY_EN` defined: `out_par` is registered with `out_data` as `^rd_data` at the WAIT→SEND edge, so `out_data` plus `out_par` has even parity.
- `Q_READ_PARITY_EN` undefined: the port still exists, `out_par` is tied to 0, and no parity logic is built.

## Test plan
- **Reset:** assert `rst` mid-SEND → all outputs 0 in the same cycle. After release, with `start` low, outputs stay idle.
- **Full transaction:** DEPTH=7, buffer[i]=0x10+i, `out_ready`=1, `start` in cycle 0.
  - Words 0x10..0x16 delivered with `out_valid` high in cycles 3,6,…,21.
  - `done` pulses only in cycle 22; `busy` high in cycles 1–22.
- **Backpressure:** `out_ready`=0 for 5 cycles on word 2.
  - `out_data`=0x12 held stable, with no extra `rd_en`.
  - Transfer completes 1 cycle after `out_ready` rises; `done` is 5 cycles later than the unstalled case.
- **Ignored start:**
  - `start` pulsed during READ, SEND and DONE → ignored; exactly 7 words and one `done`.
  - `start` in cycle e+1 → new transaction begins.
- **DEPTH=1:** one word at `rd_addr`=0, then `done`; `rd_addr` never leaves 0.
- **Parity:**
  - With `Q_READ_PARITY_EN`: word 0x07 → `out_par`=1; word 0x03 → `out_par`=0.
  - Without `Q_READ_PARITY_EN`: `out_par`=0 throughout.

Source files
------------

// File: rtl/q_proj_reader.sv
// Readout sequencer for the Q_PROJECTION result buffer: walks addresses 0..DEPTH-1
// through a registered-read memory onto a valid/ready stream. Q_READ_PARITY_EN adds out_par.
module q_proj_reader #(
    parameter int DEPTH  = 7,
    parameter int DATA_W = 8,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_par,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t state;

    // rd_addr doubles as the word counter; it is only advanced on a non-final handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= READ;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                    end
                end
                READ: begin
                    rd_en <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    out_data  <= rd_data;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (rd_addr == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                            rd_en   <= 1'b1;
                            state   <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef Q_READ_PARITY_EN
    // Captured alongside out_data so the pair carries even parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_par <= 1'b0;
        else if (state == WAIT)
            out_par <= ^rd_data;
    end
`else
    assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_q_proj_reader.sv
// Directed bench for q_proj_reader: DEPTH=7 instance for the main flows, DEPTH=1 instance
// for the single-word case; expected values are hand-derived cycle numbers and buffer words.
module tb_q_proj_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, out_ready;
    logic       rd_en, out_valid, out_par, busy, done;
    logic [2:0] rd_addr;
    logic [7:0] rd_data, out_data;

    logic       start1, out_ready1;
    logic       rd_en1, out_valid1, out_par1, busy1, done1;
    logic [0:0] rd_addr1;
    logic [7:0] rd_data1, out_data1, m1;

    logic [7:0] mem [0:7];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    q_proj_reader #(.DEPTH(7), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_par(out_par), .busy(busy), .done(done)
    );

    q_proj_reader #(.DEPTH(1), .DATA_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_par(out_par1), .busy(busy1), .done(done1)
    );

    // Registered-read buffers
    always @(posedge clk) if (rd_en)  rd_data  <= mem[rd_addr];
    always @(posedge clk) if (rd_en1) rd_data1 <= m1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] d);
`ifdef Q_READ_PARITY_EN
        return ^d;
`else
        return 1'b0 & d[0];
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".rd_en"}, rd_en, 0);
        chk({tag, ".rd_addr"}, rd_addr, 0);
        chk({tag, ".out_data"}, out_data, 0);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".out_par"}, out_par, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    task automatic run_d1(input logic [7:0] w);
        m1 = w;
        tick; start1 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick; start1 = 1'b0;
            chk("d1.rd_addr", rd_addr1, 0);
            chk("d1.rd_en", rd_en1, c == 1);
            chk("d1.valid", out_valid1, c == 3);
            chk("d1.done", done1, c == 4);
            chk("d1.busy", busy1, c >= 1 && c <= 4);
            if (c == 3) begin
                chk("d1.data", out_data1, w);
                chk("d1.par", out_par1, exp_par(w));
            end
        end
    endtask

    initial begin
        int rden_cnt, hs_cnt, done_cnt;
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        m1 = 8'h00;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; start1 = 1'b0; out_ready1 = 1'b1;
        tick; tick;
        chk_idle("rst");
        rst = 1'b0;
        tick; tick;
        chk_idle("post_rst");

        // Full transaction, out_ready held high
        tick; start = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            logic ev;
            tick; start = 1'b0;
            ev = (c % 3 == 0) && c >= 3 && c <= 21;
            chk("full.valid", out_valid, ev);
            chk("full.rd_en", rd_en, (c % 3 == 1) && c <= 19);
            chk("full.busy", busy, c >= 1 && c <= 22);
            chk("full.done", done, c == 22);
            if (c % 3 == 1 && c <= 19) chk("full.rd_addr", rd_addr, (c - 1) / 3);
            if (ev) begin
                chk("full.data", out_data, 8'h10 + 8'(c / 3 - 1));
                chk("full.par", out_par, exp_par(8'h10 + 8'(c / 3 - 1)));
            end
        end
        chk("full.hold", out_data, 8'h16);

        // Backpressure: word 2 stalled for 5 cycles
        tick; start = 1'b1;
        rden_cnt = 0;
        for (int c = 1; c <= 28; c++) begin
            tick; start = 1'b0;
            out_ready = !(c >= 9 && c <= 13);
            if (rd_en) rden_cnt++;
            if (c >= 9 && c <= 14) begin
                chk("bp.valid", out_valid, 1);
                chk("bp.data", out_data, 8'h12);
                chk("bp.rd_en", rd_en, 0);
            end
            if (c == 15) chk("bp.after", out_valid, 0);
            chk("bp.done", done, c == 27);
        end
        chk("bp.rd_en_cnt", rden_cnt, 7);
        chk("bp.idle", busy, 0);
        out_ready = 1'b1;

        // Start pulsed in READ, SEND and DONE is ignored; start at e+1 is taken
        tick; start = 1'b1;
        hs_cnt = 0; done_cnt = 0;
        for (int c = 1; c <= 23; c++) begin
            tick;
            start = (c == 1 || c == 3 || c == 22 || c == 23);
            if (out_valid && out_ready) hs_cnt++;
            if (done) done_cnt++;
            if (c == 23) chk("ign.idle_e1", busy, 0);
        end
        chk("ign.words", hs_cnt, 7);
        chk("ign.dones", done_cnt, 1);
        tick; start = 1'b0;
        chk("ign.restart_rd_en", rd_en, 1);
        chk("ign.restart_addr", rd_addr, 0);
        chk("ign.restart_busy", busy, 1);
        tick; tick;
        chk("rst.in_send", out_valid, 1);

        // Asynchronous reset mid-SEND
        rst = 1'b1;
        #1;
        chk_idle("rst_async");
        tick; rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk("rst_after.valid", out_valid, 0);
            chk("rst_after.rd_en", rd_en, 0);
            chk("rst_after.busy", busy, 0);
            chk("rst_after.done", done, 0);
        end

        // DEPTH=1, words chosen for odd and even parity
        run_d1(8'h07);
        run_d1(8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
